fetch_queue: RTL

//  Instruction prefetch/byte-alignment stage between memory and the x86 decoder.
//  - Issues sequential 32-bit word reads to memory and buffers the returned bytes in a circular byte queue.
//  - Presents a little-endian byte window to the decoder; the decoder retires a variable 1..15 bytes per cycle.
//  - Supports redirect (branch target) to any byte address, including unaligned ones.

---
 rtl/fetch_queue_pkg.sv | 17 +
 rtl/fetch_byte_queue.sv | 68 ++++++
 rtl/fetch_queue.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared constants for the instruction fetch queue: FSM encodings, word geometry,
// and a helper giving the number of bytes a fetched word contributes.
package fetch_queue_pkg;

  localparam int WORD_BYTES      = 4;
  localparam int MAX_INSTR_BYTES = 15;

  localparam logic [1:0] FSM_IDLE = 2'd0;
  localparam logic [1:0] FSM_REQ  = 2'd1;
  localparam logic [1:0] FSM_WAIT = 2'd2;

  // Bytes kept from a word whose first `skip` bytes precede the fetch target.
  function automatic logic [2:0] word_fill(input logic [1:0] skip);
    return 3'(WORD_BYTES) - {1'b0, skip};
  endfunction

endpackage

// File: rtl/fetch_byte_queue.sv
// Circular byte store: masked word write at wr_ptr, variable read advance,
// and a rotated little-endian window starting at rd_ptr.
module fetch_byte_queue
  import fetch_queue_pkg::*;
#(
  parameter int QUEUE_BYTES  = 32,
  parameter int WINDOW_BYTES = 16
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic                      i_wr_en,
  input  logic [8*WORD_BYTES-1:0]   i_wr_data,
  input  logic [1:0]                i_wr_skip,
  input  logic                      i_rd_en,
  input  logic [3:0]                i_rd_size,
  input  logic                      i_flush,
  output logic [8*WINDOW_BYTES-1:0] o_window
);

  localparam int PTR_W = $clog2(QUEUE_BYTES);

  logic [7:0]       mem_q [QUEUE_BYTES];
  logic [7:0]       mem_d [QUEUE_BYTES];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    if (i_wr_en) begin
      for (int j = 0; j < WORD_BYTES; j++) begin
        if (j >= int'(i_wr_skip))
          mem_d[wr_ptr_q + PTR_W'(j) - PTR_W'(i_wr_skip)] = i_wr_data[8*j +: 8];
      end
      wr_ptr_d = wr_ptr_q + PTR_W'(word_fill(i_wr_skip));
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    if (i_flush)
      rd_ptr_d = wr_ptr_q;
    else if (i_rd_en)
      rd_ptr_d = rd_ptr_q + PTR_W'(i_rd_size);
  end

  always_comb begin
    o_window = '0;
    for (int k = 0; k < WINDOW_BYTES; k++)
      o_window[8*k +: 8] = mem_q[rd_ptr_q + PTR_W'(k)];
  end

  // NOTE: sequential state uses non-blocking assignments; storage is reset too
  // so the window reads as zero straight out of reset.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < QUEUE_BYTES; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch and byte alignment between memory and the decoder.
// Optional FETCH_QUEUE_PERF_EN adds saturating fetch and starvation counters.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 32,
  parameter int                       QUEUE_BYTES   = 32,
  parameter int                       WINDOW_BYTES  = 16,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  output logic [ADDRESS_WIDTH-1:0]  o_mem_address,
  output logic                      o_mem_valid,
  input  logic                      i_mem_ready,
  input  logic [DATA_WIDTH-1:0]     i_mem_data,
  input  logic                      i_mem_res_valid,
  output logic [8*WINDOW_BYTES-1:0] o_window,
  output logic [4:0]                o_count,
  input  logic                      i_consume_valid,
  input  logic [3:0]                i_consume_size,
  output logic                      o_underflow,
`ifdef FETCH_QUEUE_PERF_EN
  output logic [31:0]               o_perf_fetches,
  output logic [31:0]               o_perf_starve,
`endif
  input  logic                      i_redirect,
  input  logic [ADDRESS_WIDTH-1:0]  i_redirect_addr
);

  localparam int                       OCC_W     = $clog2(QUEUE_BYTES + 1);
  localparam logic [ADDRESS_WIDTH-1:0] WORD_MASK = ~ADDRESS_WIDTH'(WORD_BYTES - 1);

  logic [1:0]               fsm_q, fsm_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]               skip_q, skip_d;
  logic                     drop_q, drop_d;
  logic                     underflow_q, underflow_d;
  logic [OCC_W-1:0]         occ_q, occ_d;

  logic resp_fire, wr_en, size_ok, consume_ok;

  assign o_count = (occ_q >= OCC_W'(WINDOW_BYTES)) ? 5'(WINDOW_BYTES) : 5'(occ_q);

  assign resp_fire  = (fsm_q == FSM_WAIT) && i_mem_res_valid;
  assign wr_en      = resp_fire && !drop_q && !i_redirect;
  assign size_ok    = (i_consume_size != 4'd0) && ({1'b0, i_consume_size} <= o_count)
                      && (i_consume_size <= 4'(MAX_INSTR_BYTES));
  assign consume_ok = i_consume_valid && !i_redirect && size_ok;

  always_comb begin
    fsm_d       = fsm_q;
    addr_d      = addr_q;
    skip_d      = skip_q;
    drop_d      = drop_q;
    underflow_d = underflow_q | (i_consume_valid && !i_redirect && !size_ok);
    occ_d       = occ_q + OCC_W'(wr_en ? word_fill(skip_q) : 3'd0)
                        - OCC_W'(consume_ok ? i_consume_size : 4'd0);

    case (fsm_q)
      FSM_IDLE: if (!i_redirect && occ_q <= OCC_W'(QUEUE_BYTES - WORD_BYTES)) fsm_d = FSM_REQ;
      FSM_REQ:  if (i_mem_ready) fsm_d = FSM_WAIT;
      FSM_WAIT: if (i_mem_res_valid) begin
        fsm_d  = FSM_IDLE;
        drop_d = 1'b0;
        // A discarded response leaves the address in place so the target is refetched.
        if (wr_en) begin
          addr_d = addr_q + ADDRESS_WIDTH'(WORD_BYTES);
          skip_d = 2'd0;
        end
      end
      default:  fsm_d = FSM_IDLE;
    endcase

    if (i_redirect) begin
      occ_d  = '0;
      addr_d = i_redirect_addr & WORD_MASK;
      skip_d = i_redirect_addr[1:0];
      drop_d = (fsm_q == FSM_REQ) || ((fsm_q == FSM_WAIT) && !i_mem_res_valid);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      fsm_q       <= FSM_IDLE;
      addr_q      <= RESET_PC & WORD_MASK;
      skip_q      <= RESET_PC[1:0];
      drop_q      <= 1'b0;
      underflow_q <= 1'b0;
      occ_q       <= '0;
    end else begin
      fsm_q       <= fsm_d;
      addr_q      <= addr_d;
      skip_q      <= skip_d;
      drop_q      <= drop_d;
      underflow_q <= underflow_d;
      occ_q       <= occ_d;
    end
  end

  assign o_mem_valid   = (fsm_q != FSM_IDLE);
  assign o_mem_address = addr_q;
  assign o_underflow   = underflow_q;

  fetch_byte_queue #(
    .QUEUE_BYTES  (QUEUE_BYTES),
    .WINDOW_BYTES (WINDOW_BYTES)
  ) u_byte_queue (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_wr_en   (wr_en),
    .i_wr_data (i_mem_data[8*WORD_BYTES-1:0]),
    .i_wr_skip (skip_q),
    .i_rd_en   (consume_ok),
    .i_rd_size (i_consume_size),
    .i_flush   (i_redirect),
    .o_window  (o_window)
  );

`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] perf_fetches_q, perf_fetches_d;
  logic [31:0] perf_starve_q, perf_starve_d;

  always_comb begin
    perf_fetches_d = perf_fetches_q;
    perf_starve_d  = perf_starve_q;
    if (wr_en && perf_fetches_q != '1) perf_fetches_d = perf_fetches_q + 32'd1;
    if (o_count == 5'd0 && !i_redirect && perf_starve_q != '1) perf_starve_d = perf_starve_q + 32'd1;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      perf_fetches_q <= '0;
      perf_starve_q  <= '0;
    end else begin
      perf_fetches_q <= perf_fetches_d;
      perf_starve_q  <= perf_starve_d;
    end
  end

  assign o_perf_fetches = perf_fetches_q;
  assign o_perf_starve  = perf_starve_q;
`endif

endmodule
